// File: rtl/time_keeper.sv
// time_keeper: divides clk down to a one-second tick, keeps a 12-hour time of
// day with an AM/PM flag, and debounces the hour-set (btnL) and minute-set
// (btnR) buttons. btnU is an asynchronous active-high reset.
module time_keeper #(
  parameter int sys_freq  = 100000000,
  parameter int db_cycles = 1000000
) (
  input  logic        clk,
  input  logic        btnU,
  input  logic        btnL,
  input  logic        btnR,
  output logic [11:0] time_bus,
  output logic        pm,
  output logic        sec_tick
);

  localparam int PW = (sys_freq > 1) ? $clog2(sys_freq) : 1;
  localparam int CW = (db_cycles > 1) ? $clog2(db_cycles) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(sys_freq - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(db_cycles - 1);

  // Button lanes: index 1 = hour set (btnL), index 0 = minute set (btnR).
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    acc;
  logic [1:0]    act;
  logic [CW-1:0] db_cnt [2];

  assign raw = {btnL, btnR};

  // Time-of-day state; time_bus is a straight concatenation of registers.
  logic [PW-1:0] presc;
  logic [5:0]    sec;
  logic [3:0]    hour;
  logic [3:0]    ten;
  logic [3:0]    mins;

  logic [PW-1:0] nxt_presc;
  logic [5:0]    nxt_sec;
  logic [3:0]    nxt_hour;
  logic [3:0]    nxt_ten;
  logic [3:0]    nxt_min;
  logic          nxt_pm;
  logic          nxt_tick;
  logic          hour_carry;
  logic          tick;

  assign tick     = (presc == PRESC_LAST);
  assign time_bus = {hour, ten, mins};

  // Synchronize, debounce and rising-edge detect both set buttons.
  always_ff @(posedge clk or posedge btnU) begin
    if (btnU) begin
      sync1 <= '0;
      sync2 <= '0;
      acc   <= '0;
      act   <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        act[i] <= 1'b0;
        if (sync2[i] != acc[i]) begin
          // Level has disagreed for db_cycles consecutive cycles: accept it.
          if (db_cnt[i] == DB_LAST) begin
            acc[i]    <= sync2[i];
            act[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Next time-of-day: minute set overrides the tick; hour set merges with
  // any tick carry so the net hour change is a single step.
  always_comb begin
    nxt_presc  = presc + PW'(1);
    nxt_sec    = sec;
    nxt_ten    = ten;
    nxt_min    = mins;
    nxt_hour   = hour;
    nxt_pm     = pm;
    nxt_tick   = 1'b0;
    hour_carry = 1'b0;
    if (act[0]) begin
      nxt_presc = '0;
      nxt_sec   = '0;
      if (mins == 4'd9) begin
        nxt_min = 4'd0;
        nxt_ten = (ten == 4'd5) ? 4'd0 : ten + 4'd1;
      end else begin
        nxt_min = mins + 4'd1;
      end
    end else if (tick) begin
      nxt_presc = '0;
      nxt_tick  = 1'b1;
      if (sec == 6'd59) begin
        nxt_sec = '0;
        if (mins == 4'd9) begin
          nxt_min = 4'd0;
          if (ten == 4'd5) begin
            nxt_ten    = 4'd0;
            hour_carry = 1'b1;
          end else begin
            nxt_ten = ten + 4'd1;
          end
        end else begin
          nxt_min = mins + 4'd1;
        end
      end else begin
        nxt_sec = sec + 6'd1;
      end
    end
    if (act[1] || hour_carry) begin
      if (hour == 4'd12) begin
        nxt_hour = 4'd1;
      end else begin
        nxt_hour = hour + 4'd1;
        if (hour == 4'd11) nxt_pm = ~pm;
      end
    end
  end

  // Register time state and the one-cycle second pulse.
  always_ff @(posedge clk or posedge btnU) begin
    if (btnU) begin
      presc    <= '0;
      sec      <= '0;
      hour     <= 4'd12;
      ten      <= 4'd0;
      mins     <= 4'd0;
      pm       <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      presc    <= nxt_presc;
      sec      <= nxt_sec;
      hour     <= nxt_hour;
      ten      <= nxt_ten;
      mins     <= nxt_min;
      pm       <= nxt_pm;
      sec_tick <= nxt_tick;
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: drives time_keeper with directed and random button activity
// and compares every cycle against a minute-resolution reference model.
module tb_time_keeper;

  localparam int SF = 10;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        btnU;
  logic        btnL;
  logic        btnR;
  logic [11:0] time_bus;
  logic        pm;
  logic        sec_tick;

  time_keeper #(.sys_freq(SF), .db_cycles(DB)) dut (
    .clk      (clk),
    .btnU     (btnU),
    .btnL     (btnL),
    .btnR     (btnR),
    .time_bus (time_bus),
    .pm       (pm),
    .sec_tick (sec_tick)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [13:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is held as hour 1..12, minute 0..59, second 0..59. A button press is
  // accepted when the last DB synchronized samples (raw delayed by two edges)
  // all disagree with the accepted level; the action lands one edge later.
  int m_hour, m_min, m_sec, m_presc;
  bit m_pm, m_tick;
  bit acc_l, acc_r, pend_l, pend_r;
  bit hist_l[$];
  bit hist_r[$];
  bit l_act, r_act, hcarry;

  function automatic bit window_differs(input bit sel_l);
    bit a;
    a = sel_l ? acc_l : acc_r;
    for (int j = 2; j < DB + 2; j++)
      if ((sel_l ? hist_l[j] : hist_r[j]) == a) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_hour = 12; m_min = 0; m_sec = 0; m_presc = 0; m_pm = 0; m_tick = 0;
    acc_l = 0; acc_r = 0; pend_l = 0; pend_r = 0;
    hist_l.delete();
    hist_r.delete();
    for (int j = 0; j < DB + 2; j++) begin
      hist_l.push_back(1'b0);
      hist_r.push_back(1'b0);
    end
  endtask

  task automatic model_adv_hour();
    m_hour = (m_hour % 12) + 1;
    if (m_hour == 12) m_pm = !m_pm;
  endtask

  always @(posedge clk or posedge btnU) begin
    if (btnU) begin
      model_reset();
      exp_q.delete();
    end else begin
      l_act = pend_l;
      r_act = pend_r;
      hist_l.push_front(btnL); void'(hist_l.pop_back());
      hist_r.push_front(btnR); void'(hist_r.pop_back());
      pend_l = 0;
      pend_r = 0;
      if (window_differs(1'b1)) begin acc_l = !acc_l; pend_l = acc_l; end
      if (window_differs(1'b0)) begin acc_r = !acc_r; pend_r = acc_r; end
      if (r_act) begin
        m_presc = 0;
        m_sec   = 0;
        m_min   = (m_min + 1) % 60;
        m_tick  = 0;
        if (l_act) model_adv_hour();
      end else begin
        m_tick = (m_presc == SF - 1);
        m_presc = m_tick ? 0 : m_presc + 1;
        hcarry = 0;
        if (m_tick) begin
          m_sec = (m_sec + 1) % 60;
          if (m_sec == 0) begin
            m_min  = (m_min + 1) % 60;
            hcarry = (m_min == 0);
          end
        end
        if (l_act || hcarry) model_adv_hour();
      end
      exp_q.push_back({m_pm, m_tick, 4'(m_hour), 4'(m_min / 10), 4'(m_min % 10)});
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!btnU && exp_q.size() > 0)
      check_eq("vec", {2'b00, pm, sec_tick, time_bus}, {2'b00, exp_q.pop_front()});
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit do_l, input bit do_r);
    btnL = do_l;
    btnR = do_r;
    cycle(6);
    btnL = 1'b0;
    btnR = 1'b0;
    cycle(12);
  endtask

  task automatic set_time(input int hr, input int mn);
    int n;
    n = (hr - m_hour + 12) % 12;
    repeat (n) press(1'b1, 1'b0);
    n = (mn - m_min + 60) % 60;
    repeat (n) press(1'b0, 1'b1);
  endtask

  task automatic edges_to_tick(output int n);
    n = -1;
    for (int i = 1; i <= 30 && n < 0; i++) begin
      @(posedge clk);
      #1;
      if (sec_tick) n = i;
    end
  endtask

  // ---------------- stimulus ----------------
  int n;
  int found;
  int glitch[6] = '{3, 1, 2, 3, 1, 2};

  initial begin
    btnU = 1'b1;
    btnL = 1'b0;
    btnR = 1'b0;
    cycle(3);
    check_eq("rst_bus", 16'(time_bus), 16'h0C00);
    check_eq("rst_pm", 16'(pm), 16'd0);
    check_eq("rst_tick", 16'(sec_tick), 16'd0);
    btnU = 1'b0;
    edges_to_tick(n);
    check_eq("first_tick", 16'(n), 16'd10);

    // Debounce: short glitches never accepted, a long hold gives one step.
    foreach (glitch[k]) begin
      btnL = 1'b1;
      cycle(glitch[k]);
      btnL = 1'b0;
      cycle(1);
    end
    cycle(10);
    check_eq("db_glitch", 16'(time_bus[11:8]), 16'hC);
    btnL = 1'b1;
    cycle(6);
    check_eq("db_early", 16'(time_bus[11:8]), 16'hC);
    cycle(1);
    check_eq("db_edge7", 16'(time_bus[11:8]), 16'h1);
    cycle(93);
    btnL = 1'b0;
    check_eq("db_hold", 16'(time_bus[11:8]), 16'h1);
    cycle(12);
    press(1'b1, 1'b0);
    check_eq("db_repress", 16'(time_bus[11:8]), 16'h2);

    // Asynchronous reset while sec_tick is high, mid-count.
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      cycle(1);
      if (sec_tick) found = 1;
    end
    check_eq("tick_wait", 16'(found), 16'd1);
    #2 btnU = 1'b1;
    #1;
    check_eq("async_bus", 16'(time_bus), 16'h0C00);
    check_eq("async_pm", 16'(pm), 16'd0);
    check_eq("async_tick", 16'(sec_tick), 16'd0);
    @(posedge clk);
    #1 btnU = 1'b0;
    edges_to_tick(n);
    check_eq("rel_tick", 16'(n), 16'd10);

    // Reset after acceptance but before the action edge drops the action.
    btnL = 1'b1;
    cycle(6);
    #2 btnU = 1'b1;
    btnL = 1'b0;
    @(posedge clk);
    #1 btnU = 1'b0;
    cycle(20);
    check_eq("db_abandon", 16'(time_bus), 16'h0C00);

    // 11:59 AM -> 12:00 PM.
    set_time(11, 59);
    check_eq("set_1159", 16'({pm, time_bus}), 16'h0B59);
    cycle(600);
    check_eq("roll_noon", 16'({pm, time_bus}), 16'h1C00);

    // Minute set at 12:59 with seconds=30: wraps to 12:00, restarts the second.
    set_time(12, 59);
    check_eq("set_1259", 16'({pm, time_bus}), 16'h1C59);
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      cycle(1);
      if (m_sec == 30) found = 1;
    end
    check_eq("sec30_wait", 16'(found), 16'd1);
    btnR = 1'b1;
    cycle(7);
    check_eq("mset_bus", 16'({pm, time_bus}), 16'h1C00);
    edges_to_tick(n);
    check_eq("mset_tick", 16'(n), 16'd10);
    btnR = 1'b0;
    cycle(12);

    // 12:59 PM -> 1:00 PM.
    set_time(12, 59);
    cycle(600);
    check_eq("roll_one", 16'({pm, time_bus}), 16'h1100);

    // 9:09 -> 9:10.
    set_time(9, 9);
    check_eq("set_909", 16'(time_bus), 16'h0909);
    found = 0;
    for (int i = 0; i < 700 && found == 0; i++) begin
      cycle(1);
      if (time_bus != 12'h909) found = 1;
    end
    check_eq("min_wait", 16'(found), 16'd1);
    check_eq("roll_910", 16'(time_bus), 16'h0910);

    // Hour set landing on the tick edge at 3:59:59.
    set_time(3, 59);
    check_eq("set_359", 16'({pm, time_bus}), 16'h0359);
    found = 0;
    for (int i = 0; i < 1300 && found == 0; i++) begin
      cycle(1);
      if (m_sec == 59 && m_presc == 3) found = 1;
    end
    check_eq("coin_wait", 16'(found), 16'd1);
    btnL = 1'b1;
    cycle(7);
    check_eq("coin_bus", 16'({pm, time_bus}), 16'h0400);
    check_eq("coin_tick", 16'(sec_tick), 16'd1);
    btnL = 1'b0;
    cycle(12);

    // Both set actions in the same cycle at 11:59 AM.
    set_time(11, 59);
    check_eq("set2_1159", 16'({pm, time_bus}), 16'h0B59);
    btnL = 1'b1;
    btnR = 1'b1;
    cycle(7);
    check_eq("both_bus", 16'({pm, time_bus}), 16'h1C00);
    check_eq("both_tick", 16'(sec_tick), 16'd0);
    edges_to_tick(n);
    check_eq("both_next", 16'(n), 16'd10);
    btnL = 1'b0;
    btnR = 1'b0;
    cycle(12);

    // Random button activity with occasional mid-cycle resets.
    for (int s = 0; s < 300; s++) begin
      btnL = 1'($urandom_range(0, 1));
      btnR = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) begin
        #2 btnU = 1'b1;
        @(posedge clk);
        #1 btnU = 1'b0;
      end else begin
        cycle($urandom_range(1, 8));
      end
    end
    btnL = 1'b0;
    btnR = 1'b0;
    cycle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
